// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the CPU bus model (master) and the timer register file (slave).
interface timer_apb_regs_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_apb_regs.sv
// APB register file of the 8-bit timer: TDR/TCR/TSR, control outputs and sticky wrap flags.
// Define APB_WAIT_STATE_EN to insert exactly one wait state into every APB transfer.
module timer_apb_regs #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  timer_apb_regs_if.slave apb,
  output logic [7:0] tdr_o,
  output logic       load_o,
  output logic       updown_o,
  output logic       en_o,
  output logic [1:0] cks_o,
  input  logic       ovf_set_i,
  input  logic       udf_set_i
);

  localparam logic [ADDR_W-1:0] AddrTdr = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrTcr = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrTsr = ADDR_W'(2);
  localparam logic [7:0]        TcrMask = 8'hB3;

  // StSetup: a setup phase was seen last cycle. StAccess: the wait-state cycle has elapsed.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  state_e state_q, state_d;

  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;

  logic       access;
  logic       ready;
  logic       xfer_done;
  logic       addr_err;
  logic       wr_commit;
  logic       wr_tdr;
  logic       wr_tcr;
  logic       wr_tsr;
  logic [7:0] rd_mux;

  // Bus phase tracking; penable without a prior setup never reaches an access.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    ready   = 1'b1;
    case (state_q)
      StIdle: begin
        if (apb.psel && !apb.penable) state_d = StSetup;
      end
      StSetup: begin
        if (!apb.psel) begin
          state_d = StIdle;
        end else if (!apb.penable) begin
          state_d = StSetup;
        end else begin
          access = 1'b1;
`ifdef APB_WAIT_STATE_EN
          ready   = 1'b0;
          state_d = StAccess;
`else
          state_d = StIdle;
`endif
        end
      end
      StAccess: begin
        if (!apb.psel) begin
          state_d = StIdle;
        end else if (!apb.penable) begin
          state_d = StSetup;
        end else begin
          access  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign xfer_done = access && ready;
  assign addr_err  = (apb.paddr > AddrTsr);
  assign wr_commit = xfer_done && apb.pwrite && !addr_err;
  assign wr_tdr    = wr_commit && (apb.paddr == AddrTdr);
  assign wr_tcr    = wr_commit && (apb.paddr == AddrTcr);
  assign wr_tsr    = wr_commit && (apb.paddr == AddrTsr);

  always_comb begin
    rd_mux = 8'h00;
    case (apb.paddr)
      AddrTdr: rd_mux = tdr_q;
      AddrTcr: rd_mux = tcr_q;
      AddrTsr: rd_mux = {6'b000000, udf_q, ovf_q};
      default: rd_mux = 8'h00;
    endcase
  end

  assign apb.prdata  = (xfer_done && !apb.pwrite) ? rd_mux : 8'h00;
  assign apb.pready  = ready;
  assign apb.pslverr = xfer_done && addr_err;

  // Flags are sticky; a set pulse beats a clearing write in the same cycle.
  always_comb begin
    tdr_d = wr_tdr ? apb.pwdata : tdr_q;
    tcr_d = wr_tcr ? (apb.pwdata & TcrMask) : tcr_q;
    ovf_d = ovf_set_i || (ovf_q && !(wr_tsr && !apb.pwdata[0]));
    udf_d = udf_set_i || (udf_q && !(wr_tsr && !apb.pwdata[1]));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      tdr_q   <= 8'h00;
      tcr_q   <= 8'h00;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Control outputs trail the register file by one cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tdr_o    <= 8'h00;
      load_o   <= 1'b0;
      updown_o <= 1'b0;
      en_o     <= 1'b0;
      cks_o    <= 2'b00;
    end else begin
      tdr_o    <= tdr_q;
      load_o   <= tcr_q[7];
      updown_o <= tcr_q[5];
      en_o     <= tcr_q[4];
      cks_o    <= tcr_q[1:0];
    end
  end

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs: register access, flags, errors, aborts and reset.
module tb_timer_apb_regs;

`ifdef APB_WAIT_STATE_EN
  localparam int AccCyc = 2;
`else
  localparam int AccCyc = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] tdr_o;
  logic       load_o;
  logic       updown_o;
  logic       en_o;
  logic [1:0] cks_o;
  logic       ovf_set_i = 1'b0;
  logic       udf_set_i = 1'b0;

  int total = 0;
  int bad   = 0;

  timer_apb_regs_if #(.ADDR_W(8)) apb ();

  timer_apb_regs #(.ADDR_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .apb       (apb),
    .tdr_o     (tdr_o),
    .load_o    (load_o),
    .updown_o  (updown_o),
    .en_o      (en_o),
    .cks_o     (cks_o),
    .ovf_set_i (ovf_set_i),
    .udf_set_i (udf_set_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; udf_pulse raises udf_set_i in the completing cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic udf_pulse, output logic [7:0] rdata, output logic err,
                      output int cycles);
    logic done;
    @(posedge sys_clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = addr; apb.pwdata = wdata;
    @(posedge sys_clk); #1;
    apb.penable = 1'b1;
    cycles = 0; done = 1'b0; rdata = 8'h00; err = 1'b0;
    while (!done && cycles < 8) begin
      @(negedge sys_clk);
      cycles++;
      if (apb.pready) begin
        done = 1'b1; rdata = apb.prdata; err = apb.pslverr; udf_set_i = udf_pulse;
      end else if (cycles < 8) begin
        @(posedge sys_clk); #1;
      end
    end
    @(posedge sys_clk); #1;
    udf_set_i = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] addr, input logic [7:0] data, output logic err);
    logic [7:0] rd;
    int cyc;
    xfer(1'b1, addr, data, 1'b0, rd, err, cyc);
    check("wr_cycles", cyc, AccCyc);
  endtask

  task automatic do_rd(input logic [7:0] addr, output logic [7:0] data, output logic err);
    int cyc;
    xfer(1'b0, addr, 8'h00, 1'b0, data, err, cyc);
    check("rd_cycles", cyc, AccCyc);
  endtask

  logic [7:0] rd;
  logic       err;
  int         cyc;

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 8'h00; apb.pwdata = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_pready", apb.pready, 1'b1);
    check("rst_pslverr", apb.pslverr, 1'b0);
    check("rst_prdata", apb.prdata, 8'h00);
    check("rst_tdr_o", tdr_o, 8'h00);
    check("rst_en_o", en_o, 1'b0);

    // Reset register values
    do_rd(8'h00, rd, err); check("rst_tdr", rd, 8'h00); check("rst_tdr_err", err, 1'b0);
    do_rd(8'h01, rd, err); check("rst_tcr", rd, 8'h00); check("rst_tcr_err", err, 1'b0);
    do_rd(8'h02, rd, err); check("rst_tsr", rd, 8'h00); check("rst_tsr_err", err, 1'b0);

    // TDR/TCR writes and control outputs
    do_wr(8'h00, 8'hA5, err); check("wr_tdr_err", err, 1'b0);
    do_wr(8'h01, 8'hFF, err); check("wr_tcr_err", err, 1'b0);
    check("en_o_lag", en_o, 1'b0);
    @(posedge sys_clk); #1;
    check("tdr_o", tdr_o, 8'hA5);
    check("load_o", load_o, 1'b1);
    check("updown_o", updown_o, 1'b1);
    check("en_o", en_o, 1'b1);
    check("cks_o", cks_o, 2'b11);
    do_rd(8'h00, rd, err); check("rd_tdr", rd, 8'hA5);
    do_rd(8'h01, rd, err); check("rd_tcr", rd, 8'hB3);

    // Sticky status flags
    @(posedge sys_clk); #1 ovf_set_i = 1'b1;
    @(posedge sys_clk); #1 ovf_set_i = 1'b0;
    do_rd(8'h02, rd, err); check("tsr_ovf", rd, 8'h01);
    do_rd(8'h02, rd, err); check("tsr_sticky", rd, 8'h01);
    do_wr(8'h02, 8'hFE, err);
    do_rd(8'h02, rd, err); check("tsr_clr", rd, 8'h00);
    xfer(1'b1, 8'h02, 8'h00, 1'b1, rd, err, cyc);
    do_rd(8'h02, rd, err); check("tsr_set_wins", rd, 8'h02);
    @(posedge sys_clk); #1 begin ovf_set_i = 1'b1; udf_set_i = 1'b1; end
    @(posedge sys_clk); #1 begin ovf_set_i = 1'b0; udf_set_i = 1'b0; end
    do_rd(8'h02, rd, err); check("tsr_both", rd, 8'h03);
    do_wr(8'h02, 8'h02, err);
    do_rd(8'h02, rd, err); check("tsr_w1_keep", rd, 8'h02);

    // Out-of-range addresses
    do_wr(8'h05, 8'h3C, err); check("bad_wr_err", err, 1'b1);
    do_rd(8'h00, rd, err); check("bad_wr_tdr", rd, 8'hA5);
    do_rd(8'h01, rd, err); check("bad_wr_tcr", rd, 8'hB3);
    do_rd(8'h07, rd, err); check("bad_rd_data", rd, 8'h00); check("bad_rd_err", err, 1'b1);

    // Reserved TCR bits
    do_wr(8'h01, 8'h5E, err);
    do_rd(8'h01, rd, err); check("tcr_rsvd", rd, 8'h12);
    check("tcr_rsvd_load", load_o, 1'b0);
    check("tcr_rsvd_cks", cks_o, 2'b10);

    // Abandoned transfer
    @(posedge sys_clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 8'h00; apb.pwdata = 8'h77;
`ifdef APB_WAIT_STATE_EN
    @(posedge sys_clk); #1 apb.penable = 1'b1;
    @(negedge sys_clk); check("abort_wait", apb.pready, 1'b0);
`endif
    @(posedge sys_clk); #1 begin apb.psel = 1'b0; apb.penable = 1'b0; end
    do_rd(8'h00, rd, err); check("abort_tdr", rd, 8'hA5);

    // penable without setup
    @(posedge sys_clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b1;
    apb.paddr = 8'h00; apb.pwdata = 8'h99;
    @(negedge sys_clk); check("nosetup_pready", apb.pready, 1'b1);
    check("nosetup_err", apb.pslverr, 1'b0);
    @(posedge sys_clk); #1 begin apb.psel = 1'b0; apb.penable = 1'b0; end
    do_rd(8'h00, rd, err); check("nosetup_tdr", rd, 8'hA5);

    // Reset during the access phase of a TCR write
    check("pre_rst_en_o", en_o, 1'b1);
    @(posedge sys_clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 8'h01; apb.pwdata = 8'h12;
    @(posedge sys_clk); #1 apb.penable = 1'b1;
    #2 sys_rst = 1'b1;
    #1 check("rst_async_en_o", en_o, 1'b0);
    @(posedge sys_clk); #1 begin apb.psel = 1'b0; apb.penable = 1'b0; end
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("midrst_pready", apb.pready, 1'b1);
    check("midrst_en_o", en_o, 1'b0);
    check("midrst_tdr_o", tdr_o, 8'h00);
    do_rd(8'h01, rd, err); check("midrst_tcr", rd, 8'h00);
    do_rd(8'h00, rd, err); check("midrst_tdr", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
